// File: rtl/serial_pkg.sv
// serial_pkg: shared definitions for the serial operand path.
// Holds the default operand width and the loader FSM state encoding;
// the downstream serial adder imports the same package.
package serial_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/piso_shift.sv
// piso_shift: WIDTH-bit parallel-in / serial-out register, LSB first.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-low reset, clears the register
//   load  - capture din (wins over shift)
//   shift - shift right by one, zero fill
//   din   - parallel load value
//   lsb   - current bit 0 of the register
module piso_shift #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             lsb
);

    logic [WIDTH-1:0] sr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            sr <= '0;
        else if (load)
            sr <= din;
        else if (shift)
            sr <= {1'b0, sr[WIDTH-1:1]};
    end

    assign lsb = sr[0];

endmodule

// File: rtl/serial_operand_loader.sv
// serial_operand_loader: accepts a parallel operand pair (a, b) and streams
// it LSB first, one bit of each per beat, to a serial adder.
// Ports:
//   clk, rst             - clock, asynchronous active-low reset
//   in_valid / in_ready  - parallel input handshake for a, b
//   a, b                 - WIDTH-bit operands
//   out_valid / out_ready- serial output handshake
//   a_bit, b_bit         - current operand bits
//   first / last         - beat is bit 0 / bit WIDTH-1
module serial_operand_loader
    import serial_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             a_bit,
    output logic             b_bit,
    output logic             first,
    output logic             last
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t        state, state_next;
    logic [CW-1:0] count;
    logic          load, beat, shift_en;
    logic          a_lsb, b_lsb;

    assign out_valid = (state == SHIFT);
    assign first     = out_valid && (count == '0);
    assign last      = out_valid && (count == LAST_CNT);

    // Accepting during the consumed last beat lets a new pair follow with no bubble.
    assign in_ready  = (state == IDLE) || (last && out_ready);
    assign load      = in_valid && in_ready;
    assign beat      = out_valid && out_ready;
    assign shift_en  = beat && !last;

    // The registers still hold the top bit after the last beat, so mask in IDLE.
    assign a_bit = out_valid && a_lsb;
    assign b_bit = out_valid && b_lsb;

    always_comb begin
        state_next = state;
        if (load)
            state_next = SHIFT;
        else if (beat && last)
            state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            if (load)
                count <= '0;
            else if (shift_en)
                count <= count + CW'(1);
        end
    end

    piso_shift #(.WIDTH(WIDTH)) u_sr_a (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .shift(shift_en),
        .din  (a),
        .lsb  (a_lsb)
    );

    piso_shift #(.WIDTH(WIDTH)) u_sr_b (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .shift(shift_en),
        .din  (b),
        .lsb  (b_lsb)
    );

endmodule

// File: tb/tb_serial_operand_loader.sv
module tb_serial_operand_loader;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         out_valid;
    logic         out_ready;
    logic         a_bit, b_bit, first, last;

    int n_cmp = 0;
    int n_err = 0;

    serial_operand_loader #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .a_bit    (a_bit),
        .b_bit    (b_bit),
        .first    (first),
        .last     (last)
    );

    always #5 clk = ~clk;

    // Present a pair, let the next rising edge take it, then withdraw it.
    task automatic load_pair(input logic [W-1:0] va, input logic [W-1:0] vb);
        in_valid = 1'b1; a = va; b = vb;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        #12;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if ({first, last, a_bit, b_bit} !== 4'b0000) begin n_err++; $display("FAIL reset_flags got %b want 0000", {first, last, a_bit, b_bit}); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        logic [W-1:0] ea, eb;
        ea = 4'b1011; eb = 4'b0110;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic_idle_ready got %b want 1", in_ready); end
        load_pair(ea, eb);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({out_valid, a_bit, b_bit, first, last} !== {1'b1, ea[i], eb[i], i == 0, i == W-1}) begin
                n_err++;
                $display("FAIL basic_beat%0d got v/a/b/f/l=%b want %b", i, {out_valid, a_bit, b_bit, first, last},
                         {1'b1, ea[i], eb[i], i == 0, i == W-1});
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_cmp++; if ({out_valid, in_ready, a_bit, b_bit} !== 4'b0100) begin n_err++; $display("FAIL basic_idle_after got v/r/a/b=%b want 0100", {out_valid, in_ready, a_bit, b_bit}); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] a2, b2;
        a2 = 4'hF; b2 = 4'h1;
        load_pair(4'b1011, 4'b0110);
        for (int i = 0; i < W-1; i++) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b1; a = a2; b = b2;
        @(negedge clk);
        n_cmp++; if ({last, in_ready} !== 2'b11) begin n_err++; $display("FAIL b2b_last_ready got l/r=%b want 11", {last, in_ready}); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({out_valid, a_bit, b_bit, first, last} !== {1'b1, a2[i], b2[i], i == 0, i == W-1}) begin
                n_err++;
                $display("FAIL b2b_beat%0d got v/a/b/f/l=%b want %b", i, {out_valid, a_bit, b_bit, first, last},
                         {1'b1, a2[i], b2[i], i == 0, i == W-1});
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_idle got %b want 0", out_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_stall;
        logic [W-1:0] ea;
        ea = 4'b0101;
        load_pair(ea, 4'b0000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({out_valid, a_bit, first, last, in_ready} !== 5'b11000) begin
                n_err++;
                $display("FAIL stall_hold%0d got v/a/f/l/r=%b want 11000", c, {out_valid, a_bit, first, last, in_ready});
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if ({a_bit, first, last} !== 3'b100) begin n_err++; $display("FAIL stall_release got a/f/l=%b want 100", {a_bit, first, last}); end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if ({out_valid, a_bit, last} !== 3'b101) begin n_err++; $display("FAIL stall_beat3 got v/a/l=%b want 101", {out_valid, a_bit, last}); end
        @(posedge clk); #1;
    endtask

    task automatic test_ignore;
        logic [W-1:0] ea, eb;
        ea = 4'b0110; eb = 4'b0011;
        load_pair(ea, eb);
        in_valid = 1'b1; a = 4'h9; b = 4'h9;
        for (int i = 0; i < W; i++) begin
            if (i == W-1) in_valid = 1'b0;
            @(negedge clk);
            n_cmp++;
            if ({a_bit, b_bit, first, last} !== {ea[i], eb[i], i == 0, i == W-1}) begin
                n_err++;
                $display("FAIL ignore_beat%0d got a/b/f/l=%b want %b", i, {a_bit, b_bit, first, last}, {ea[i], eb[i], i == 0, i == W-1});
            end
            if (i < W-1) begin
                n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL ignore_ready%0d got %b want 0", i, in_ready); end
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ignore_idle got %b want 0", out_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        logic [W-1:0] e3;
        e3 = 4'h3;
        load_pair(4'b0010, 4'b0011);
        @(posedge clk); #1;
        n_cmp++; if ({a_bit, b_bit} !== 2'b11) begin n_err++; $display("FAIL rmid_beat1 got a/b=%b want 11", {a_bit, b_bit}); end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, first, last, a_bit, b_bit, in_ready} !== 6'b000001) begin
            n_err++;
            $display("FAIL rmid_async got v/f/l/a/b/r=%b want 000001", {out_valid, first, last, a_bit, b_bit, in_ready});
        end
        in_valid = 1'b1; a = e3; b = 4'h0;
        #1 rst = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({out_valid, a_bit, b_bit, first, last} !== {1'b1, e3[i], 1'b0, i == 0, i == W-1}) begin
                n_err++;
                $display("FAIL rmid_beat%0d got v/a/b/f/l=%b want %b", i, {out_valid, a_bit, b_bit, first, last},
                         {1'b1, e3[i], 1'b0, i == 0, i == W-1});
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sweep;
        logic [W-1:0] va, vb, ra, rb;
        logic [W:0]   sum, exp_sum;
        logic         cy, flag_bad;
        int           k, guard;
        for (int p = 0; p < 1000; p++) begin
            va = W'($urandom); vb = W'($urandom);
            load_pair(va, vb);
            ra = '0; rb = '0; sum = '0; cy = 1'b0; flag_bad = 1'b0;
            k = 0; guard = 0;
            while (k < W && guard < 100) begin
                out_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                if (out_valid && out_ready) begin
                    if (first !== (k == 0) || last !== (k == W-1)) flag_bad = 1'b1;
                    ra[k]  = a_bit;
                    rb[k]  = b_bit;
                    sum[k] = a_bit ^ b_bit ^ cy;
                    cy     = (a_bit & b_bit) | (a_bit & cy) | (b_bit & cy);
                    k++;
                end
                guard++;
                @(posedge clk); #1;
            end
            out_ready = 1'b1;
            sum[W] = cy;
            exp_sum = {1'b0, va} + {1'b0, vb};
            n_cmp++; if (k != W) begin n_err++; $display("FAIL sweep%0d_beats got %0d want %0d", p, k, W); end
            n_cmp++; if ({ra, rb} !== {va, vb}) begin n_err++; $display("FAIL sweep%0d_recon got %h/%h want %h/%h", p, ra, rb, va, vb); end
            n_cmp++; if (sum !== exp_sum) begin n_err++; $display("FAIL sweep%0d_sum got %h want %h", p, sum, exp_sum); end
            n_cmp++; if (flag_bad !== 1'b0) begin n_err++; $display("FAIL sweep%0d_flags got bad=%b want 0", p, flag_bad); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_ignore();
        test_reset_mid();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_operand_loader.md
SERIAL_OPERAND_LOADER -- requirements
Module: serial_operand_loader

Interface
REQ-001 Parameter WIDTH, default 4: operand width in bits, legal range 2..16.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 in_valid  input  1  upstream offers an operand pair on a/b.
REQ-005 in_ready  output  1  block accepts the pair this cycle.
REQ-006 a  input  WIDTH  operand A, parallel.
REQ-007 b  input  WIDTH  operand B, parallel.
REQ-008 out_valid  output  1  a_bit/b_bit/first/last carry a valid beat.
REQ-009 out_ready  input  1  downstream serial adder consumes the current beat.
REQ-010 a_bit  output  1  current bit of A, LSB first.
REQ-011 b_bit  output  1  current bit of B, LSB first.
REQ-012 first  output  1  beat is bit 0; downstream clears its carry.
REQ-013 last  output  1  beat is bit WIDTH-1; downstream emits the final carry.

Function
REQ-014 The block SHALL implement a two-state FSM: IDLE, SHIFT.
REQ-015 Input handshake SHALL occur on a rising edge where in_valid && in_ready.
REQ-016 in_ready SHALL equal (state==IDLE) || (state==SHIFT && last && out_ready); combinational.
REQ-017 On input handshake the block SHALL load a and b into WIDTH-bit shift registers, clear the bit counter to 0 and enter or stay in SHIFT.
REQ-018 In SHIFT out_valid SHALL be 1; in IDLE out_valid SHALL be 0.
REQ-019 a_bit/b_bit SHALL be bit 0 of the respective shift register; both SHALL be 0 in IDLE.
REQ-020 first SHALL be out_valid && (count==0); last SHALL be out_valid && (count==WIDTH-1).
REQ-021 On an output beat (out_valid && out_ready) not flagged last, both shift registers SHALL shift right by one with 0 fill, and the counter SHALL increment.
REQ-022 On a last beat without a simultaneous input handshake, the FSM SHALL return to IDLE.
REQ-023 On a last beat with a simultaneous input handshake, the new pair SHALL load with no bubble, so first follows last on the next cycle.
REQ-024 While out_valid && !out_ready, all outputs and state SHALL hold unchanged for any number of cycles.
REQ-025 in_valid in SHIFT before the last beat SHALL be ignored, because in_ready is 0.
REQ-026 The counter SHALL be $clog2(WIDTH) bits wide and SHALL never exceed WIDTH-1.
REQ-027 A pair SHALL take exactly WIDTH output beats, one bit per beat, with no stalls on out_ready.

Reset
REQ-028 When rst=0, the block SHALL immediately force state=IDLE, shift registers=0, counter=0, out_valid=0, a_bit=0, b_bit=0, first=0, last=0, and in_ready=1.
REQ-029 Reset asserted mid-operation SHALL discard the in-flight pair with no further beats.
REQ-030 After rst returns to 1, the first possible load SHALL be on the next rising edge.

Structure
REQ-031 A shared package serial_pkg SHALL hold the WIDTH default and the FSM state enum (IDLE, SHIFT); the downstream adder imports the same package.
REQ-032 One sub-module, piso_shift, SHALL be instantiated twice, once for A and once for B. It is a WIDTH-bit parallel-load, shift-enable register.
REQ-033 FSM and counter SHALL live in the top module; no other sub-modules.

Verification
REQ-034 Basic: WIDTH=4, a=4'b1011, b=4'b0110, out_ready=1.
- a_bit sequence 1,1,0,1; b_bit sequence 0,1,1,0.
- first on beat 0 only, last on beat 3 only, then IDLE.
REQ-035 Back-to-back: second pair a=4'hF, b=4'h1 presented during the last beat.
- in_ready=1 on that beat.
- Next cycle first=1, a_bit=1, b_bit=1, with no idle cycle.
REQ-036 Stall: out_ready=0 for 3 cycles at beat 2 of a=4'b0101.
- a_bit=1, first=0, last=0 held for all 3 cycles.
- Sequence resumes with a_bit=0 on beat 3.
REQ-037 Ignore: in_valid=1 with a=4'h9 during beats 0-2 of a pair.
- in_ready=0 throughout.
- The in-flight bit sequence is unchanged.
REQ-038 Reset mid-op: rst=0 asynchronously between edges at beat 1.
- out_valid, first, last, a_bit and b_bit go to 0 at once, in_ready=1.
- After release, a new pair a=4'h3 starts with first=1.
REQ-039 Bench sweep: 1000 random pairs with random out_ready stalls.
- Serially reconstructed A and B SHALL match the loaded values.
- Serial sum from a reference adder SHALL equal a+b (WIDTH+1 bits).
